c2h_axis_tlp_segmenter: RTL

//  Drains the C2H AXI4-Stream FIFO output into PCIe memory-write segments. Per transfer descriptor (address, byte length)
//  it splits the stream into segments of at most MAX_PAYLOAD_BYTES that never cross a 4 KiB boundary.
//  It emits one header (address, length) per segment, followed by that segment's data beats with tlast on the final beat.

---
 rtl/c2h_axis_tlp_segmenter_pkg.sv | 36 +++
 rtl/c2h_axis_tlp_segmenter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/c2h_axis_tlp_segmenter_pkg.sv
// Shared definitions for the C2H stream-to-TLP segmenter: page geometry,
// FSM state encoding and the segment-length helper.
package c2h_axis_tlp_segmenter_pkg;

  // Memory-write segments must never cross a page of this size.
  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_BITS  = 12;
  // Wide enough to hold the full value PAGE_BYTES (a segment starting on a
  // page boundary has a whole page of room).
  localparam int SEG_W      = PAGE_BITS + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // waiting for a descriptor
    ST_HDR   = 3'd1,  // presenting the header of the next segment
    ST_DATA  = 3'd2,  // passing payload beats of the current segment
    ST_PAD   = 3'd3,  // payload ended early: zero-fill the current segment
    ST_DRAIN = 3'd4   // transfer complete but payload continues: discard it
  } seg_state_t;

  // Segment length = smallest of the remaining bytes, the max payload size
  // and the room left in the current page. All operands are pre-clipped to
  // SEG_W bits by the caller.
  function automatic logic [SEG_W-1:0] seg_len_min(
    input logic [SEG_W-1:0] rem,
    input logic [SEG_W-1:0] mps,
    input logic [SEG_W-1:0] page
  );
    logic [SEG_W-1:0] m;
    m = (rem < mps) ? rem : mps;
    if (page < m) begin
      m = page;
    end
    return m;
  endfunction

endpackage

// File: rtl/c2h_axis_tlp_segmenter.sv
// C2H segmenter: turns one descriptor (address, byte length) plus the FIFO
// payload stream into a sequence of memory-write segments. Each segment gets
// a header (address, length) followed by its payload beats, tlast on the
// final beat. Segments are at most MAX_PAYLOAD_BYTES and never straddle a
// 4 KiB page.
//
// Handshake rules for every interface (s_desc, s_axis, m_hdr, m_axis): a
// transfer happens on a rising clk edge where valid and ready are both high.
// Once an output asserts valid it holds valid and its payload stable until
// the matching ready is seen. Header fields come straight from registers so
// they are stable for the whole HDR state; payload beats in DATA are a
// zero-latency pass-through, so their stability is that of the upstream FIFO.
module c2h_axis_tlp_segmenter
  import c2h_axis_tlp_segmenter_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int ADDR_WIDTH        = 64,
  parameter int LEN_WIDTH         = 20,
  parameter int MAX_PAYLOAD_BYTES = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_WIDTH-1:0]                s_desc_addr,
  input  logic [LEN_WIDTH-1:0]                 s_desc_len,
  input  logic                                 s_desc_valid,
  output logic                                 s_desc_ready,
  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]              s_axis_tkeep,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  output logic [ADDR_WIDTH-1:0]                m_hdr_addr,
  output logic [$clog2(MAX_PAYLOAD_BYTES):0]   m_hdr_len,
  output logic                                 m_hdr_valid,
  input  logic                                 m_hdr_ready,
  output logic [DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]              m_axis_tkeep,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 status_busy,
  output logic                                 status_len_error,
  output logic [2:0]                           dbg_state
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int BEAT_BYTES = KEEP_WIDTH;
  // Byte-offset bits within one beat; assumes at least two bytes per beat.
  localparam int OFF_BITS   = $clog2(BEAT_BYTES);
  localparam int HLEN_W     = $clog2(MAX_PAYLOAD_BYTES) + 1;
  // Beats per segment never exceed MAX_PAYLOAD_BYTES / BEAT_BYTES.
  localparam int BCNT_W     = HLEN_W - OFF_BITS;

  seg_state_t            state;
  seg_state_t            state_next;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  rem_len;
  logic [BCNT_W-1:0]     beat_cnt;
  logic                  len_error;

  // Byte enables are not used: every beat is treated as fully populated.
  logic unused_keep;
  assign unused_keep = ^s_axis_tkeep;

  // ---------------------------------------------------------------------------
  // Segment length from the current address / remaining byte count
  // ---------------------------------------------------------------------------
  logic [SEG_W-1:0]  rem_clip;
  logic [SEG_W-1:0]  page_room;
  logic [SEG_W-1:0]  seg_min;
  logic [HLEN_W-1:0] seg_len;

  // Remaining length only matters up to one page, so clip it to SEG_W bits.
  assign rem_clip  = (rem_len >= LEN_WIDTH'(PAGE_BYTES)) ? SEG_W'(PAGE_BYTES)
                                                         : {1'b0, rem_len[PAGE_BITS-1:0]};
  // A page-aligned address yields the full page (4096), not zero.
  assign page_room = SEG_W'(PAGE_BYTES) - {1'b0, cur_addr[PAGE_BITS-1:0]};
  assign seg_min   = seg_len_min(rem_clip, SEG_W'(MAX_PAYLOAD_BYTES), page_room);
  // The minimum is bounded by MAX_PAYLOAD_BYTES, so it fits HLEN_W bits.
  assign seg_len   = HLEN_W'(seg_min);

  // ---------------------------------------------------------------------------
  // Descriptor decode and handshake events
  // ---------------------------------------------------------------------------
  logic                  desc_fire;
  logic                  desc_addr_bad;
  logic                  desc_len_bad;
  logic                  desc_len_zero;
  logic [LEN_WIDTH-1:0]  desc_len_trunc;
  logic [ADDR_WIDTH-1:0] desc_addr_align;
  logic                  hdr_fire;
  logic                  data_fire;
  logic                  pad_fire;
  logic                  seg_done;
  logic                  xfer_done;
  logic                  early_last;
  logic                  drain_end;
  logic                  err_event;

  assign desc_fire       = s_desc_valid && (state == ST_IDLE);
  assign desc_addr_bad   = |s_desc_addr[OFF_BITS-1:0];
  assign desc_len_bad    = |s_desc_len[OFF_BITS-1:0];
  assign desc_len_trunc  = {s_desc_len[LEN_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign desc_addr_align = {s_desc_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign desc_len_zero   = (desc_len_trunc == '0);

  assign hdr_fire   = (state == ST_HDR) && m_hdr_ready;
  assign data_fire  = (state == ST_DATA) && s_axis_tvalid && m_axis_tready;
  assign pad_fire   = (state == ST_PAD) && m_axis_tready;
  assign seg_done   = (beat_cnt == BCNT_W'(1));
  // Last beat of the last segment of the transfer.
  assign xfer_done  = seg_done && (rem_len == LEN_WIDTH'(seg_len));
  // Upstream ended the payload before the descriptor length was reached.
  assign early_last = data_fire && s_axis_tlast && !xfer_done;
  assign drain_end  = (state == ST_DRAIN) && s_axis_tvalid && s_axis_tlast;

  // One error pulse per offending event; several faults on one descriptor
  // (misaligned address and length) share a single pulse.
  assign err_event  = (desc_fire && (desc_addr_bad || desc_len_bad || desc_len_zero))
                    || early_last || drain_end;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register; reset abandons any segment in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode from the handshake events above.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (desc_fire && !desc_len_zero) begin
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hdr_fire) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_fire) begin
          if (s_axis_tlast && !xfer_done) begin
            // Early end: zero-fill the rest of this segment. If it ended
            // exactly on a segment boundary there is nothing left to fill.
            state_next = seg_done ? ST_IDLE : ST_PAD;
          end else if (seg_done) begin
            if (xfer_done) begin
              state_next = s_axis_tlast ? ST_IDLE : ST_DRAIN;
            end else begin
              state_next = ST_HDR;
            end
          end
        end
      end
      ST_PAD: begin
        if (pad_fire && seg_done) begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_end) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-state outputs; DATA is a combinational pass-through of the FIFO.
  always_comb begin
    s_desc_ready  = 1'b0;
    s_axis_tready = 1'b0;
    m_hdr_valid   = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (state)
      ST_IDLE: begin
        s_desc_ready = 1'b1;
      end
      ST_HDR: begin
        m_hdr_valid = 1'b1;
      end
      ST_DATA: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = seg_done;
        s_axis_tready = m_axis_tready;
      end
      ST_PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = seg_done;
      end
      ST_DRAIN: begin
        s_axis_tready = 1'b1;
      end
      default: begin
        s_desc_ready = 1'b0;
      end
    endcase
  end

  // Header fields are register-derived so they stay stable while waiting.
  assign m_hdr_addr   = cur_addr;
  assign m_hdr_len    = seg_len;
  assign m_axis_tkeep = '1;
  assign status_busy  = (state != ST_IDLE);
  assign dbg_state    = state;
  assign status_len_error = len_error;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------

  // Transfer position, per-segment beat counter and the registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      rem_len   <= '0;
      beat_cnt  <= '0;
      len_error <= 1'b0;
    end else begin
      len_error <= err_event;
      if (desc_fire) begin
        cur_addr <= desc_addr_align;
        rem_len  <= desc_len_trunc;
      end
      if (hdr_fire) begin
        beat_cnt <= BCNT_W'(seg_len >> OFF_BITS);
      end
      if (data_fire || pad_fire) begin
        beat_cnt <= beat_cnt - BCNT_W'(1);
      end
      if (data_fire && seg_done) begin
        cur_addr <= cur_addr + ADDR_WIDTH'(seg_len);
        rem_len  <= rem_len - LEN_WIDTH'(seg_len);
      end
    end
  end

endmodule
